// File: rtl/timer_alarm.sv
// timer_alarm: buzzer sequencer behind the countdown timer.
// It rings at 1 Hz for a bounded window and supports ack and a limited number of snoozes.
// If the alarm rings out without an ack, it sets a sticky "missed" flag.
module timer_alarm #(
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 10,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       timer_done,
  input  logic       ack,
  input  logic       snooze,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       missed,
  output logic [2:0] snooze_used,
  output logic [5:0] alarm_sec
);

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned SNZ_W  = 3;
  localparam logic [SEC_W-1:0] RING_LOAD   = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LOAD = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [SNZ_W-1:0] SNOOZE_MAX  = SNZ_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_MISSED  = 2'd3
  } state_t;

  state_t           state_q;
  logic             td_q;
  logic             sn_q;
  logic             buzzer_q;
  logic             active_q;
  logic             missed_q;
  logic [SNZ_W-1:0] snooze_used_q;
  logic [SEC_W-1:0] alarm_sec_q;

  logic td_rise;
  logic sn_rise;

  // Rising-edge detect against the previous-cycle samples.
  assign td_rise = timer_done & ~td_q;
  assign sn_rise = snooze & ~sn_q;

  assign buzzer       = buzzer_q;
  assign alarm_active = active_q;
  assign missed       = missed_q;
  assign snooze_used  = snooze_used_q;
  assign alarm_sec    = alarm_sec_q;

  // Alarm sequencer: state plus all registered outputs; reset has top priority.
  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      td_q          <= 1'b0;
      sn_q          <= 1'b0;
      buzzer_q      <= 1'b0;
      active_q      <= 1'b0;
      missed_q      <= 1'b0;
      snooze_used_q <= '0;
      alarm_sec_q   <= '0;
    end else begin
      td_q <= timer_done;
      sn_q <= snooze;
      case (state_q)
        ST_IDLE: begin
          buzzer_q    <= 1'b0;
          active_q    <= 1'b0;
          alarm_sec_q <= '0;
          if (ack) missed_q <= 1'b0;
          if (td_rise) begin
            state_q       <= ST_RINGING;
            buzzer_q      <= 1'b1;
            active_q      <= 1'b1;
            alarm_sec_q   <= RING_LOAD;
            snooze_used_q <= '0;
          end
        end
        ST_RINGING: begin
          if (!timer_done) begin
            state_q     <= ST_IDLE;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            alarm_sec_q <= '0;
          end else if (ack) begin
            state_q     <= ST_IDLE;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            alarm_sec_q <= '0;
            missed_q    <= 1'b0;
          end else if (sn_rise && (snooze_used_q < SNOOZE_MAX)) begin
            state_q       <= ST_SNOOZE;
            buzzer_q      <= 1'b0;
            alarm_sec_q   <= SNOOZE_LOAD;
            snooze_used_q <= snooze_used_q + SNZ_W'(1);
          end else if (alarm_sec_q == '0) begin
            state_q  <= ST_MISSED;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
            missed_q <= 1'b1;
          end else begin
            alarm_sec_q <= alarm_sec_q - SEC_W'(1);
            buzzer_q    <= ~buzzer_q;
          end
        end
        ST_SNOOZE: begin
          if (!timer_done || ack) begin
            state_q     <= ST_IDLE;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            alarm_sec_q <= '0;
            if (ack) missed_q <= 1'b0;
          end else if (alarm_sec_q == '0) begin
            state_q     <= ST_RINGING;
            buzzer_q    <= 1'b1;
            alarm_sec_q <= RING_LOAD;
          end else begin
            alarm_sec_q <= alarm_sec_q - SEC_W'(1);
            buzzer_q    <= 1'b0;
          end
        end
        ST_MISSED: begin
          buzzer_q    <= 1'b0;
          active_q    <= 1'b0;
          alarm_sec_q <= '0;
          missed_q    <= 1'b1;
          if (ack) begin
            state_q  <= ST_IDLE;
            missed_q <= 1'b0;
          end else if (td_rise) begin
            state_q       <= ST_RINGING;
            buzzer_q      <= 1'b1;
            active_q      <= 1'b1;
            alarm_sec_q   <= RING_LOAD;
            snooze_used_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
